// File: rtl/ntt_cmd_sequencer.sv
// Host-command front-end for the NTT1024 core: turns valid/ready commands and data
// into single-cycle OP_CODE pulses, din_valid/din0 beats and a per-command done pulse.
module ntt_cmd_sequencer #(
   parameter int DW   = 32,
   parameter int OPW  = 5,
   parameter int LENW = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [OPW-1:0]  cmd_op,
   input  logic [1:0]      cmd_mode,
   input  logic [LENW-1:0] cmd_len,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   input  logic            core_done,
   output logic [OPW-1:0]  OP_CODE,
   output logic            din_valid,
   output logic [DW-1:0]   din0,
   output logic            busy,
   output logic            cmd_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_DRAIN,
      S_WAIT,
      S_FLUSH
   } state_t;

   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_DRAIN = 2'b10;
   localparam logic [1:0] MODE_WAIT  = 2'b11;

   state_t          state;
   logic [1:0]      mode_r;
   logic [LENW-1:0] len_r;
   logic [LENW-1:0] cnt;
   logic [LENW-1:0] cnt_nxt;

   assign cnt_nxt   = cnt + 1'b1;
   assign cmd_ready = (state == S_IDLE);
   assign s_ready   = (state == S_LOAD) && (cnt < len_r);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mode_r    <= '0;
         len_r     <= '0;
         cnt       <= '0;
         OP_CODE   <= '0;
         din_valid <= 1'b0;
         din0      <= '0;
         busy      <= 1'b0;
         cmd_done  <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here and are raised only by the state that owns them.
         OP_CODE   <= '0;
         din_valid <= 1'b0;
         cmd_done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  mode_r <= cmd_mode;
                  len_r  <= cmd_len;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (cmd_op == '0) begin
                     state <= S_FLUSH;
                  end else begin
                     OP_CODE <= cmd_op;
                     state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (mode_r == MODE_LOAD && len_r != '0) begin
                  state <= S_LOAD;
               end else if (mode_r == MODE_DRAIN && len_r != '0) begin
                  // First drain beat is launched here so it lands on the cycle right after ISSUE.
                  din_valid <= 1'b1;
                  din0      <= '0;
                  cnt       <= cnt_nxt;
                  state     <= (cnt_nxt == len_r) ? S_FLUSH : S_DRAIN;
               end else if (mode_r == MODE_WAIT) begin
                  state <= S_WAIT;
               end else begin
                  state <= S_FLUSH;
               end
            end
            S_LOAD: begin
               if (s_valid && s_ready) begin
                  din_valid <= 1'b1;
                  din0      <= s_data;
                  cnt       <= cnt_nxt;
                  if (cnt_nxt == len_r) state <= S_FLUSH;
               end
            end
            S_DRAIN: begin
               din_valid <= 1'b1;
               din0      <= '0;
               cnt       <= cnt_nxt;
               if (cnt_nxt == len_r) state <= S_FLUSH;
            end
            S_WAIT: begin
               if (core_done) state <= S_FLUSH;
            end
            S_FLUSH: begin
               // The last data beat is on the core's input this cycle; done follows it.
               cmd_done <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ntt_cmd_sequencer.md
Name: ntt_cmd_sequencer

Overview:
- Upstream front-end of the NTT1024 core. Turns host commands and data words into the core's own input protocol: `OP_CODE` pulses, `din_valid` and `din0`.
- Covers four kinds of command: parameter, twiddle and coefficient loads; result drain; start commands that must wait on the core's `done`.
- Host side uses valid/ready handshakes. The core has no backpressure, so the sequencer absorbs host stalls and guarantees the required idle cycle between commands.

Parameters:
- DW, 32, data word width (`s_data`, `din0`).
- OPW, 5, opcode width.
- LENW, 12, beat-count width (max 4095; covers 511 twiddles, 1024 coefficients, 520 drain beats).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: sequencer accepts a command.
- `cmd_op` in OPW: opcode forwarded to the core.
- `cmd_mode` in 2: 00 none, 01 load, 10 drain, 11 wait-done.
- `cmd_len` in LENW: beats for load/drain; ignored for none and wait-done.
- `s_valid` in 1: host data valid.
- `s_ready` out 1: sequencer takes a data word.
- `s_data` in DW: host data word.
- `core_done` in 1: core `done`.
- `OP_CODE` out OPW: to core.
- `din_valid` out 1: to core.
- `din0` out DW: to core.
- `busy` out 1: state != IDLE.
- `cmd_done` out 1: one-cycle pulse when a command completes.

Behaviour:
- All outputs are registered except `cmd_ready` and `s_ready`, which are decoded from state.
- Reset values: `OP_CODE`=0, `din_valid`=0, `din0`=0, `cmd_done`=0, `busy`=0. State goes to IDLE and beat counter to 0.
- Reset mid-command aborts immediately. No partial pulse is emitted after the reset cycle.
- States: IDLE, ISSUE, LOAD, DRAIN, WAIT, FLUSH.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, latch op/mode/len and go to ISSUE.
  - If op==0, skip ISSUE, go straight to FLUSH, never drive a nonzero `OP_CODE`.
- ISSUE (exactly 1 cycle): `OP_CODE`=op. All other cycles `OP_CODE`=0. Next state:
  - mode 01 with len>0 → LOAD.
  - mode 10 with len>0 → DRAIN.
  - mode 11 → WAIT.
  - otherwise → FLUSH.
- LOAD:
  - `s_ready`=1 while beats accepted < len.
  - Each `s_valid`&`s_ready` registers `din_valid`=1 and `din0`=`s_data` on the next cycle. The counter increments.
  - A cycle with `s_valid`=0 produces `din_valid`=0 next cycle; `din0` holds its last value.
  - After the len-th handshake → FLUSH. The core therefore sees exactly len beats.
- DRAIN:
  - `din_valid`=1 for exactly len consecutive cycles, starting the cycle after ISSUE. `din0`=0.
  - `s_ready`=0, so host data is untouched. Then → FLUSH.
- WAIT:
  - `din_valid`=0.
  - Stay until `core_done`=1 is sampled, then → FLUSH.
  - `core_done` already high on entry is honoured on the first WAIT cycle.
  - `core_done` seen in any other state is ignored.
- FLUSH (exactly 1 cycle after the last `din_valid` beat, or after ISSUE/WAIT):
  - `din_valid`=0 and `cmd_done`=1.
  - Next state IDLE, so a new `OP_CODE` is at least 2 cycles after the last data beat.
- `cmd_len`=0 with load/drain behaves as mode none.
- `busy`=1 in every state except IDLE.
- `s_valid` asserted outside LOAD is ignored and not consumed.
- Counter width is LENW; it never wraps because it stops at len.

Test Plan:
- After reset, hold `cmd_valid`=0 → `OP_CODE`=0, `din_valid`=0, `cmd_ready`=1, `busy`=0 for 10 cycles.
- Load, no stall: mode 01, op=00001, len=3, `s_data`={1, 12289, 0x1E01} with `s_valid`=1.
  - ISSUE cycle: `OP_CODE`=00001.
  - Then 3 consecutive `din_valid` beats with `din0`=1, 12289, 0x1E01.
  - Then 1 cycle `din_valid`=0 with `cmd_done`=1; `cmd_ready`=1 the cycle after.
- Load with stalls: mode 01, op=00011, len=1024, `s_valid` toggling 1-0-1.
  - Exactly 1024 `din_valid` beats, in order, with gaps matching the stalls.
  - No beat is lost or duplicated; `s_ready` drops after beat 1024.
- Drain: mode 10, op=01011, len=520 → `OP_CODE` pulse, then 520 consecutive `din_valid`=1 with `din0`=0, no `s_ready`, then FLUSH.
- Wait-done: mode 11, op=00100, `core_done` raised 50 cycles later → sequencer stays busy with `din_valid`=0 throughout, `cmd_done` pulses 2 cycles after `core_done` is sampled.
- Reset in LOAD after 100 of 511 beats → next cycle all outputs 0, state IDLE. A new op=00010, len=2 command then runs normally with exactly 2 beats.
